// File: rtl/id_exe_reg_if.sv
// Bus between the ID stage and the ID/EXE pipeline register.
// Optional macro ID_EXE_FWD_SRC_EN adds the forwarding-unit source fields.
interface id_exe_reg_if #(
  parameter int WORD_W = 32,
  parameter int CNT_W  = 16
);
  // Pipeline control
  logic              flush;
  logic              freeze;
  logic              cond_fail_in;

  // Decoded instruction entering the register
  logic [3:0]        exe_cmd_in;
  logic              mem_r_en_in;
  logic              mem_w_en_in;
  logic              wb_en_in;
  logic              s_in;
  logic              b_in;
  logic [WORD_W-1:0] pc_in;
  logic [WORD_W-1:0] val_rn_in;
  logic [WORD_W-1:0] val_rm_in;
  logic              imm_in;
  logic [11:0]       shift_operand_in;
  logic [23:0]       signed_imm_24_in;
  logic [3:0]        dest_in;
  logic              carry_in;

  // Registered instruction presented to EXE
  logic [3:0]        exe_cmd;
  logic              mem_r_en;
  logic              mem_w_en;
  logic              wb_en;
  logic              s;
  logic              b;
  logic [WORD_W-1:0] pc;
  logic [WORD_W-1:0] val_rn;
  logic [WORD_W-1:0] val_rm;
  logic              imm;
  logic [11:0]       shift_operand;
  logic [23:0]       signed_imm_24;
  logic [3:0]        dest;
  logic              carry;
  logic              valid;
  logic [CNT_W-1:0]  bubble_cnt;

`ifdef ID_EXE_FWD_SRC_EN
  logic [3:0]        src1_in;
  logic [3:0]        src2_in;
  logic [1:0]        two_src_in;
  logic [3:0]        src1;
  logic [3:0]        src2;
  logic [1:0]        two_src;
`endif

  modport master (
`ifdef ID_EXE_FWD_SRC_EN
    output src1_in, src2_in, two_src_in,
    input  src1, src2, two_src,
`endif
    output flush, freeze, cond_fail_in,
    output exe_cmd_in, mem_r_en_in, mem_w_en_in, wb_en_in, s_in, b_in,
    output pc_in, val_rn_in, val_rm_in, imm_in, shift_operand_in,
    output signed_imm_24_in, dest_in, carry_in,
    input  exe_cmd, mem_r_en, mem_w_en, wb_en, s, b,
    input  pc, val_rn, val_rm, imm, shift_operand, signed_imm_24, dest, carry,
    input  valid, bubble_cnt
  );

  modport slave (
`ifdef ID_EXE_FWD_SRC_EN
    input  src1_in, src2_in, two_src_in,
    output src1, src2, two_src,
`endif
    input  flush, freeze, cond_fail_in,
    input  exe_cmd_in, mem_r_en_in, mem_w_en_in, wb_en_in, s_in, b_in,
    input  pc_in, val_rn_in, val_rm_in, imm_in, shift_operand_in,
    input  signed_imm_24_in, dest_in, carry_in,
    output exe_cmd, mem_r_en, mem_w_en, wb_en, s, b,
    output pc, val_rn, val_rm, imm, shift_operand, signed_imm_24, dest, carry,
    output valid, bubble_cnt
  );
endinterface

// File: rtl/id_exe_reg.sv
// ID/EXE pipeline register with freeze, flush and condition-fail bubbles.
// Optional macro ID_EXE_FWD_SRC_EN registers src1/src2/two_src for forwarding.
module id_exe_reg #(
  parameter int WORD_W = 32,
  parameter int CNT_W  = 16
) (
  input logic         clk,
  input logic         rst,
  id_exe_reg_if.slave bus
);

  // Fields that a bubble must neutralise
  typedef struct packed {
    logic [3:0] exe_cmd;
    logic       mem_r_en;
    logic       mem_w_en;
    logic       wb_en;
    logic       s;
    logic       b;
    logic       valid;
`ifdef ID_EXE_FWD_SRC_EN
    logic [1:0] two_src;
`endif
  } ctrl_t;

  // Fields that a condition-fail bubble still carries into EXE
  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] val_rn;
    logic [WORD_W-1:0] val_rm;
    logic              imm;
    logic [11:0]       shift_operand;
    logic [23:0]       signed_imm_24;
    logic [3:0]        dest;
    logic              carry;
`ifdef ID_EXE_FWD_SRC_EN
    logic [3:0]        src1;
    logic [3:0]        src2;
`endif
  } data_t;

  ctrl_t            ctrl_q, ctrl_load;
  data_t            data_q, data_load;
  logic [CNT_W-1:0] cnt_q, cnt_inc;

  // NOTE: every variable gets a default at the top of always_comb so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    ctrl_load = '0;
    data_load = '0;

    data_load.pc            = bus.pc_in;
    data_load.val_rn        = bus.val_rn_in;
    data_load.val_rm        = bus.val_rm_in;
    data_load.imm           = bus.imm_in;
    data_load.shift_operand = bus.shift_operand_in;
    data_load.signed_imm_24 = bus.signed_imm_24_in;
    data_load.dest          = bus.dest_in;
    data_load.carry         = bus.carry_in;
`ifdef ID_EXE_FWD_SRC_EN
    data_load.src1          = bus.src1_in;
    data_load.src2          = bus.src2_in;
`endif

    // A failed condition leaves ctrl_load at zero: the slot becomes a bubble
    if (!bus.cond_fail_in) begin
      ctrl_load.exe_cmd  = bus.exe_cmd_in;
      ctrl_load.mem_r_en = bus.mem_r_en_in;
      ctrl_load.mem_w_en = bus.mem_w_en_in;
      ctrl_load.wb_en    = bus.wb_en_in;
      ctrl_load.s        = bus.s_in;
      ctrl_load.b        = bus.b_in;
      ctrl_load.valid    = 1'b1;
`ifdef ID_EXE_FWD_SRC_EN
      ctrl_load.two_src  = bus.two_src_in;
`endif
    end

    cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q <= '0;
      data_q <= '0;
      cnt_q  <= '0;
    end else if (bus.flush) begin
      ctrl_q <= '0;
      data_q <= '0;
      cnt_q  <= cnt_inc;
    end else if (!bus.freeze) begin
      ctrl_q <= ctrl_load;
      data_q <= data_load;
      if (bus.cond_fail_in) cnt_q <= cnt_inc;
    end
  end

  assign bus.exe_cmd       = ctrl_q.exe_cmd;
  assign bus.mem_r_en      = ctrl_q.mem_r_en;
  assign bus.mem_w_en      = ctrl_q.mem_w_en;
  assign bus.wb_en         = ctrl_q.wb_en;
  assign bus.s             = ctrl_q.s;
  assign bus.b             = ctrl_q.b;
  assign bus.valid         = ctrl_q.valid;
  assign bus.pc            = data_q.pc;
  assign bus.val_rn        = data_q.val_rn;
  assign bus.val_rm        = data_q.val_rm;
  assign bus.imm           = data_q.imm;
  assign bus.shift_operand = data_q.shift_operand;
  assign bus.signed_imm_24 = data_q.signed_imm_24;
  assign bus.dest          = data_q.dest;
  assign bus.carry         = data_q.carry;
  assign bus.bubble_cnt    = cnt_q;
`ifdef ID_EXE_FWD_SRC_EN
  assign bus.src1          = data_q.src1;
  assign bus.src2          = data_q.src2;
  assign bus.two_src       = ctrl_q.two_src;
`endif

endmodule

// File: doc/id_exe_reg.md
Name: id_exe_reg

Overview:
- ID/EXE pipeline register of the 5-stage ARM core. It sits directly downstream of the ID-stage control decoder and register file.
- Captures decoded control (exe_cmd, mem_r_en, mem_w_en, wb_en, s, b) plus operands, and presents them to the EXE stage one cycle later.
- Handles hazard freeze, branch flush and condition-fail bubble insertion.
- Keeps a saturating count of bubbles injected into EXE, for performance debug.

Parameters:
- WORD_W, 32, width of PC and register operands
- CNT_W, 16, width of the bubble counter

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  branch taken in EXE; kill the instruction entering EXE
- freeze  in  1  hazard stall; hold all register contents
- cond_fail_in  in  1  ID condition check failed; the instruction becomes a bubble
- exe_cmd_in  in  4  ALU command from the decoder
- mem_r_en_in, mem_w_en_in, wb_en_in, s_in, b_in  in  1 each  decoder controls
- pc_in  in  WORD_W  PC+4 of the ID instruction
- val_rn_in, val_rm_in  in  WORD_W  register file read data
- imm_in  in  1  I bit
- shift_operand_in  in  12  shifter operand field
- signed_imm_24_in  in  24  branch offset
- dest_in  in  4  Rd
- carry_in  in  1  current status-register C flag
- exe_cmd  out  4  registered control
- mem_r_en, mem_w_en, wb_en, s, b  out  1 each  registered controls
- pc, val_rn, val_rm  out  WORD_W  registered data
- imm  out  1  registered I bit
- shift_operand  out  12  registered shifter operand
- signed_imm_24  out  24  registered branch offset
- dest  out  4  registered Rd
- carry  out  1  registered C flag
- valid  out  1  EXE holds a real instruction
- bubble_cnt  out  CNT_W  saturating count of bubbles injected

Behaviour:
- All updates on the rising edge of clk.
- Priority, highest first: rst > flush > freeze > load.
- rst: every output clears to 0, including valid and bubble_cnt.
- flush (regardless of freeze):
  - all control outputs and valid clear to 0;
  - data outputs clear to 0;
  - bubble_cnt increments.
- freeze with no flush: every output holds, including bubble_cnt.
- load with cond_fail_in=1:
  - mem_r_en, mem_w_en, wb_en, s, b clear to 0 and exe_cmd loads 0;
  - valid=0;
  - data fields (pc, val_rn, val_rm, imm, shift_operand, signed_imm_24, dest, carry) still load;
  - bubble_cnt increments.
- load with cond_fail_in=0: all fields load from their inputs and valid=1.
- A value of exe_cmd_in that contains x (branch mode) is stored as-is. No defined meaning is given to it, because b=1 makes EXE ignore it.
- Latency: an input is visible at the outputs one cycle after the edge on which it is loaded.
- bubble_cnt saturates at all-ones and never wraps.
- The pipeline always advances through EXE. One bubble counts once: a held cycle is not recounted.
- No combinational path runs from any input to any output.

Optional Feature:
- Macro: ID_EXE_FWD_SRC_EN.
- Defined:
  - adds inputs src1_in[3:0], src2_in[3:0] and two_src_in[1:0];
  - adds registered outputs src1, src2 and two_src for the forwarding unit;
  - these follow the same rst/flush/freeze/load rules as dest, and clear on flush and reset;
  - on a load with cond_fail_in=1, two_src loads 0 so that a bubble never requests forwarding.
- Undefined: none of these ports exist, and the rest of the behaviour is unchanged.

Test Plan:
- Reset: assert rst for 2 cycles with all inputs nonzero -> every output 0, valid=0, bubble_cnt=0.
- Normal load: exe_cmd_in=0110, wb_en_in=1, dest_in=5, val_rn_in=0x0000_00AA -> next cycle exe_cmd=0110, wb_en=1, dest=5, val_rn=0xAA, valid=1.
- Freeze: load an instruction, then freeze=1 for 3 cycles with different inputs -> outputs stay at the first values and bubble_cnt does not change.
- Flush beats freeze: flush=1 and freeze=1 with mem_w_en_in=1 -> next cycle mem_w_en=0, valid=0, pc=0, bubble_cnt +1.
- Condition fail: cond_fail_in=1, mem_r_en_in=1, wb_en_in=1, dest_in=3 -> mem_r_en=0, wb_en=0, exe_cmd=0, valid=0, dest=3, bubble_cnt +1.
- Saturation: CNT_W=4, apply 20 consecutive flushes -> bubble_cnt holds at 15. A reset mid-sequence returns it to 0.
